// File: rtl/apb_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module   : apb_slave_mem
//  Purpose  : APB3 completer with a word-addressed register memory, a fixed
//             number of PREADY-low wait cycles and PSLVERR for bad addresses.
//             Optional APB4 write strobes when APB_SLAVE_PSTRB_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_SLAVE_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int NBYTE = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_DEPTH * 4);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [NBYTE-1:0]      strb_q, strb_d;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  w_setup;
  logic                  w_err;
  logic                  w_mem_we;
  logic [NBYTE-1:0]      w_strb_in;
  logic                  w_rd_strb_err;
  logic [IDX_W-1:0]      w_idx;

`ifdef APB_SLAVE_PSTRB_EN
  assign w_strb_in     = PSTRB;
  assign w_rd_strb_err = !PWRITE && (PSTRB != '0);
`else
  assign w_strb_in     = '1;
  assign w_rd_strb_err = 1'b0;
`endif

  assign w_setup = PSEL && !PENABLE;
  assign w_idx   = PADDR[IDX_W+1:2];
  assign w_err   = (PADDR[1:0] != 2'b00) || (PADDR >= ADDR_LIMIT) || w_rd_strb_err;

  // Completion is decoded from state/counter; a dropped PSEL never reports ready.
  assign PREADY  = (state_q == ACCESS) && (cnt_q == 4'd0) && PSEL;
  assign PSLVERR = PREADY && err_q;
  assign PRDATA  = prdata_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    write_d  = write_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    prdata_d = prdata_q;
    w_mem_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_setup) begin
          state_d  = ACCESS;
          cnt_d    = 4'(WAIT_STATES);
          idx_d    = w_idx;
          write_d  = PWRITE;
          err_d    = w_err;
          wdata_d  = PWDATA;
          strb_d   = w_strb_in;
          prdata_d = (!PWRITE && !w_err) ? mem_q[w_idx] : '0;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d  = IDLE;
          prdata_d = '0;
        end else if (PENABLE) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d  = IDLE;
            prdata_d = '0;
            w_mem_we = write_q && !err_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      prdata_q <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      prdata_q <= prdata_d;
      if (w_mem_we) begin
        for (int b = 0; b < NBYTE; b++) begin
          if (strb_q[b]) begin
            mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
`default_nettype none
// Bench for apb_slave_mem: three instances (WAIT_STATES 0, 2, 3) driven by
// directed APB transfers and checked against a word-array memory model.
module tb_apb_slave_mem;

  localparam int NDUT = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NDUT-1:0]   psel = '0;
  logic [NDUT-1:0]   penable = '0;
  logic [NDUT-1:0]   pwrite = '0;
  logic [31:0]       paddr  [NDUT];
  logic [31:0]       pwdata [NDUT];
  logic [3:0]        pstrb  [NDUT];
  logic [31:0]       prdata [NDUT];
  logic [NDUT-1:0]   pready;
  logic [NDUT-1:0]   pslverr;

  int checks = 0;
  int errors = 0;

  logic [31:0]       mdl [NDUT][16];
  bit   [NDUT-1:0]   chk_en = '0;
  bit   [NDUT-1:0]   exp_rdy = '0;
  bit   [NDUT-1:0]   exp_err = '0;
  bit   [NDUT-1:0]   exp_isrd = '0;
  logic [31:0]       exp_rd [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    apb_slave_mem #(.WAIT_STATES(g == 0 ? 0 : (g == 1 ? 2 : 3))) u_dut (
      .PCLK    (clk),
      .PRESET  (rst),
      .PSEL    (psel[g]),
      .PENABLE (penable[g]),
      .PADDR   (paddr[g]),
      .PWRITE  (pwrite[g]),
      .PWDATA  (pwdata[g]),
`ifdef APB_SLAVE_PSTRB_EN
      .PSTRB   (pstrb[g]),
`endif
      .PRDATA  (prdata[g]),
      .PREADY  (pready[g]),
      .PSLVERR (pslverr[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < 16; i++) mdl[d][i] = '0;
  endtask

  // Per-cycle comparison against the model expectation of the active access cycle.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (chk_en[d]) begin
        chk($sformatf("dut%0d PREADY", d), {31'b0, pready[d]}, {31'b0, exp_rdy[d]});
        if (exp_rdy[d]) begin
          chk($sformatf("dut%0d PSLVERR", d), {31'b0, pslverr[d]}, {31'b0, exp_err[d]});
          if (exp_isrd[d]) chk($sformatf("dut%0d PRDATA", d), prdata[d], exp_rd[d]);
        end
      end
    end
  end

  // One APB transfer; abort_at >= 0 drops PSEL in that access cycle.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] strb, input int abort_at,
                      output logic [31:0] rd, output bit slv, output int nw);
    int  w = ws_of(d);
    bit  err = (addr[1:0] != 2'b00) || (addr >= 32'd64);
    int  idx = int'(addr[5:2]);
    bit  got = 0;
    bit  aborted = 0;
    logic [31:0] merged;
`ifdef APB_SLAVE_PSTRB_EN
    if (!wr && strb != 4'h0) err = 1;
`endif
    rd = 'x; slv = 0; nw = -1;
    psel[d] = 1; penable[d] = 0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wd; pstrb[d] = strb;
    @(posedge clk); #1;
    penable[d] = 1;
    paddr[d] = ~addr; pwdata[d] = ~wd; pstrb[d] = ~strb;
    for (int k = 0; k <= w; k++) begin
      if (abort_at == k) begin
        psel[d] = 0; penable[d] = 0;
        exp_rdy[d] = 0; chk_en[d] = 1;
        @(negedge clk);
        @(posedge clk); #1;
        aborted = 1;
        break;
      end
      chk_en[d] = 1; exp_rdy[d] = (k == w); exp_err[d] = err; exp_isrd[d] = !wr;
      exp_rd[d] = err ? 32'h0 : mdl[d][idx];
      @(negedge clk);
      if (pready[d] && !got) begin
        got = 1; nw = k; rd = prdata[d]; slv = pslverr[d];
      end
      @(posedge clk); #1;
    end
    chk_en[d] = 0;
    psel[d] = 0; penable[d] = 0;
    if (wr && !err && !aborted) begin
      merged = mdl[d][idx];
      for (int b = 0; b < 4; b++) begin
`ifdef APB_SLAVE_PSTRB_EN
        if (strb[b]) merged[8*b +: 8] = wd[8*b +: 8];
`else
        merged[8*b +: 8] = wd[8*b +: 8];
`endif
      end
      mdl[d][idx] = merged;
    end
  endtask

  logic [31:0] rd;
  bit          slv;
  int          nw;

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
    end
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("reset PREADY dut%0d", d), {31'b0, pready[d]}, 32'h0);
      chk($sformatf("reset PSLVERR dut%0d", d), {31'b0, pslverr[d]}, 32'h0);
      chk($sformatf("reset PRDATA dut%0d", d), prdata[d], 32'h0);
    end
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // Zero-wait write then read
    xfer(0, 1, 32'h08, 32'hDEADBEEF, 4'hF, -1, rd, slv, nw);
    chk("zw write ready cycle", nw, 0);
    chk("zw write slverr", {31'b0, slv}, 0);
    xfer(0, 0, 32'h08, 32'h0, 4'h0, -1, rd, slv, nw);
    chk("zw read ready cycle", nw, 0);
    chk("zw read data", rd, 32'hDEADBEEF);

    // Protocol violation: PENABLE with PSEL while idle is ignored
    psel[0] = 1; penable[0] = 1; paddr[0] = 32'h08; pwrite[0] = 0;
    @(negedge clk); chk("idle violation PREADY", {31'b0, pready[0]}, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("idle violation PREADY hold", {31'b0, pready[0]}, 0);
    @(posedge clk); #1;
    psel[0] = 0; penable[0] = 0;

    // Back-to-back transfers with no idle cycles
    xfer(0, 1, 32'h0, 32'd1, 4'hF, -1, rd, slv, nw);
    xfer(0, 1, 32'h4, 32'd2, 4'hF, -1, rd, slv, nw);
    xfer(0, 1, 32'h8, 32'd3, 4'hF, -1, rd, slv, nw);
    xfer(0, 0, 32'h0, 32'h0, 4'h0, -1, rd, slv, nw); chk("b2b read 0", rd, 32'd1);
    xfer(0, 0, 32'h4, 32'h0, 4'h0, -1, rd, slv, nw); chk("b2b read 4", rd, 32'd2);
    xfer(0, 0, 32'h8, 32'h0, 4'h0, -1, rd, slv, nw); chk("b2b read 8", rd, 32'd3);

    // Error decode and upper boundary on the WAIT_STATES=2 instance
    xfer(1, 1, 32'h40, 32'hFFFFFFFF, 4'hF, -1, rd, slv, nw);
    chk("oob write slverr", {31'b0, slv}, 1);
    xfer(1, 0, 32'h00, 32'h0, 4'h0, -1, rd, slv, nw);
    chk("read 0 after oob write", rd, 32'h0);
    xfer(1, 0, 32'h02, 32'h0, 4'h0, -1, rd, slv, nw);
    chk("misaligned slverr", {31'b0, slv}, 1);
    chk("misaligned data", rd, 32'h0);
    xfer(1, 1, 32'h3C, 32'h00000055, 4'hF, -1, rd, slv, nw);
    xfer(1, 0, 32'h3C, 32'h0, 4'h0, -1, rd, slv, nw);
    chk("last word read", rd, 32'h55);
    chk("last word slverr", {31'b0, slv}, 0);

    // Abort a write after one access cycle
    xfer(1, 1, 32'h0C, 32'hA5A5A5A5, 4'hF, 1, rd, slv, nw);
    chk("abort no PREADY", nw, -1);
    xfer(1, 0, 32'h0C, 32'h0, 4'h0, -1, rd, slv, nw);
    chk("read after abort", rd, 32'h0);

    // Wait states on the WAIT_STATES=3 instance
    xfer(2, 1, 32'h04, 32'h12345678, 4'hF, -1, rd, slv, nw);
    xfer(2, 0, 32'h04, 32'h0, 4'h0, -1, rd, slv, nw);
    chk("ws3 low cycles", nw, 3);
    chk("ws3 read data", rd, 32'h12345678);

    // Reset asserted while PREADY is high
    psel[2] = 1; penable[2] = 0; pwrite[2] = 0; paddr[2] = 32'h04;
    @(posedge clk); #1;
    penable[2] = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre-reset PREADY", {31'b0, pready[2]}, 1);
    chk("pre-reset PRDATA", prdata[2], 32'h12345678);
    rst = 1;
    #1;
    chk("async reset PREADY", {31'b0, pready[2]}, 0);
    chk("async reset PRDATA", prdata[2], 32'h0);
    psel[2] = 0; penable[2] = 0;
    @(posedge clk); #1;
    rst = 0;
    clear_model();
    @(posedge clk); #1;
    xfer(2, 0, 32'h04, 32'h0, 4'h0, -1, rd, slv, nw);
    chk("read after reset dut2", rd, 32'h0);
    xfer(0, 0, 32'h08, 32'h0, 4'h0, -1, rd, slv, nw);
    chk("read after reset dut0", rd, 32'h0);

`ifdef APB_SLAVE_PSTRB_EN
    xfer(0, 1, 32'h10, 32'h11223344, 4'b1111, -1, rd, slv, nw);
    xfer(0, 1, 32'h10, 32'hAABBCCDD, 4'b0101, -1, rd, slv, nw);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, -1, rd, slv, nw);
    chk("strobe merge", rd, 32'h11BB33DD);
    xfer(0, 0, 32'h10, 32'h0, 4'h1, -1, rd, slv, nw);
    chk("read with strobe slverr", {31'b0, slv}, 1);
    chk("read with strobe data", rd, 32'h0);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
